// File: rtl/ccu_pkg.sv
// Shared types and constants for the CCU snoop path: ACE snoop channel structs,
// CR response bit positions and the snoop fan-out FSM state encoding.
package ccu_pkg;

  localparam int unsigned CR_DATA_TRANSFER = 0;
  localparam int unsigned CR_ERROR         = 1;
  localparam int unsigned CR_PASS_DIRTY    = 2;
  localparam int unsigned CR_IS_SHARED     = 3;
  localparam int unsigned CR_WAS_UNIQUE    = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [3:0]  snoop;
  } ac_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } ccu_snoop_req_t;

  typedef struct packed {
    logic       ac_ready;
    logic       cr_valid;
    logic [4:0] cr_resp;
    logic       cd_valid;
    cd_chan_t   cd;
  } ccu_snoop_resp_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BCAST   = 3'd1,
    S_COLLECT = 3'd2,
    S_RESP    = 3'd3,
    S_DATA    = 3'd4
  } snoop_state_e;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE=0 returns the index of the lowest set bit,
// MODE=1 the number of leading zeros; empty_o flags an all-zero input.
module lzc #(
  parameter int unsigned WIDTH = 2,
  parameter bit          MODE  = 1'b0,
  localparam int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  always_comb begin
    cnt_o = '0;
    if (MODE == 1'b0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/ccu_snoop_bcast.sv
// Snoop fan-out/fan-in: broadcasts one AC to all non-initiating masters, merges
// their CR responses and forwards one CD stream while draining the others.
module ccu_snoop_bcast
  import ccu_pkg::*;
#(
  parameter int unsigned NoMstPorts   = 4,
  parameter type         snoop_req_t  = ccu_snoop_req_t,
  parameter type         snoop_resp_t = ccu_snoop_resp_t,
  localparam int unsigned IdxW = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  snoop_req_t  snoop_req_i,
  input  logic [IdxW-1:0] initiator_i,
  output snoop_resp_t snoop_resp_o,
  output snoop_req_t  snoop_req_o  [NoMstPorts],
  input  snoop_resp_t snoop_resp_i [NoMstPorts]
);

  typedef logic [IdxW-1:0] idx_t;

  snoop_state_e          state_q, state_d;
  ac_chan_t              ac_q, ac_d;
  logic [NoMstPorts-1:0] tgt_q, tgt_d, acc_q, acc_d, got_q, got_d;
  logic [NoMstPorts-1:0] dt_q, dt_d, done_q, done_d;
  logic [4:0]            crresp_q, crresp_d;
  idx_t                  sel_q, sel_d, sel_lzc;
  logic                  dt_empty;
  logic [NoMstPorts-1:0] ac_hs, cr_hs, cd_hs;

  lzc #(.WIDTH(NoMstPorts), .MODE(1'b0)) i_lzc (
    .in_i   (dt_q),
    .cnt_o  (sel_lzc),
    .empty_o(dt_empty)
  );

  always_comb begin
    snoop_resp_o = '0;
    ac_hs        = '0;
    cr_hs        = '0;
    cd_hs        = '0;
    // ac_ready is gated by reset so every output is low while rst_ni is held
    if (state_q == S_IDLE) snoop_resp_o.ac_ready = rst_ni;
    if (state_q == S_RESP) begin
      snoop_resp_o.cr_valid = 1'b1;
      snoop_resp_o.cr_resp  = crresp_q;
    end
    for (int i = 0; i < NoMstPorts; i++) begin
      snoop_req_o[i] = '0;
      case (state_q)
        S_BCAST: if (tgt_q[i]) begin
          snoop_req_o[i].ac_valid = ~acc_q[i];
          snoop_req_o[i].ac       = ac_q;
        end
        S_COLLECT: snoop_req_o[i].cr_ready = tgt_q[i] & ~got_q[i];
        S_DATA: if (dt_q[i] && !done_q[i]) begin
          if (idx_t'(i) == sel_q) begin
            snoop_req_o[i].cd_ready = snoop_req_i.cd_ready;
            snoop_resp_o.cd_valid   = snoop_resp_i[i].cd_valid;
            snoop_resp_o.cd         = snoop_resp_i[i].cd;
          end else begin
            snoop_req_o[i].cd_ready = 1'b1;
          end
        end
        default: ;
      endcase
      ac_hs[i] = snoop_req_o[i].ac_valid & snoop_resp_i[i].ac_ready;
      cr_hs[i] = snoop_req_o[i].cr_ready & snoop_resp_i[i].cr_valid;
      cd_hs[i] = snoop_req_o[i].cd_ready & snoop_resp_i[i].cd_valid;
    end
  end

  always_comb begin
    state_d  = state_q;
    ac_d     = ac_q;
    tgt_d    = tgt_q;
    acc_d    = acc_q;
    got_d    = got_q;
    dt_d     = dt_q;
    done_d   = done_q;
    crresp_d = crresp_q;
    sel_d    = sel_q;
    case (state_q)
      S_IDLE: if (snoop_req_i.ac_valid) begin
        ac_d = snoop_req_i.ac;
        for (int i = 0; i < NoMstPorts; i++) tgt_d[i] = (initiator_i != idx_t'(i));
        state_d = (tgt_d == '0) ? S_RESP : S_BCAST;
      end
      S_BCAST: begin
        acc_d = acc_q | ac_hs;
        if (acc_d == tgt_q) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        got_d = got_q | cr_hs;
        for (int i = 0; i < NoMstPorts; i++) begin
          if (cr_hs[i]) begin
            crresp_d = crresp_d | snoop_resp_i[i].cr_resp;
            dt_d[i]  = snoop_resp_i[i].cr_resp[CR_DATA_TRANSFER];
          end
        end
        if (got_d == tgt_q) state_d = S_RESP;
      end
      S_RESP: begin
        if (!dt_empty) sel_d = sel_lzc;
        if (snoop_req_i.cr_ready) state_d = (dt_q != '0) ? S_DATA : S_IDLE;
      end
      S_DATA: begin
        for (int i = 0; i < NoMstPorts; i++)
          done_d[i] = done_q[i] | (cd_hs[i] & snoop_resp_i[i].cd.last);
        if ((done_d & dt_q) == dt_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && state_d == S_IDLE) begin
      acc_d    = '0;
      got_d    = '0;
      dt_d     = '0;
      done_d   = '0;
      crresp_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      ac_q     <= '0;
      tgt_q    <= '0;
      acc_q    <= '0;
      got_q    <= '0;
      dt_q     <= '0;
      done_q   <= '0;
      crresp_q <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      ac_q     <= ac_d;
      tgt_q    <= tgt_d;
      acc_q    <= acc_d;
      got_q    <= got_d;
      dt_q     <= dt_d;
      done_q   <= done_d;
      crresp_q <= crresp_d;
      sel_q    <= sel_d;
    end
  end

endmodule

// File: tb/tb_ccu_snoop_bcast.sv
// Directed bench for ccu_snoop_bcast: a 4-port instance for broadcast, merge,
// data select/drain, backpressure and reset, plus a 1-port instance.
module tb_ccu_snoop_bcast;
  import ccu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ccu_snoop_req_t  req4, req1;
  ccu_snoop_resp_t resp4, resp1;
  logic [1:0]      ini4;
  logic [0:0]      ini1;
  ccu_snoop_req_t  preq4  [4];
  ccu_snoop_resp_t presp4 [4];
  ccu_snoop_req_t  preq1  [1];
  ccu_snoop_resp_t presp1 [1];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cr_hs_cnt = 0;
  int   hs0;
  int   p2, p3;
  logic up;
  logic mon_p1 = 1'b0;
  logic p1_seen = 1'b0;

  ccu_snoop_bcast #(.NoMstPorts(4)) dut4 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .snoop_req_i (req4),
    .initiator_i (ini4),
    .snoop_resp_o(resp4),
    .snoop_req_o (preq4),
    .snoop_resp_i(presp4)
  );

  ccu_snoop_bcast #(.NoMstPorts(1)) dut1 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .snoop_req_i (req1),
    .initiator_i (ini1),
    .snoop_resp_o(resp1),
    .snoop_req_o (preq1),
    .snoop_resp_i(presp1)
  );

  always @(negedge clk) begin
    if (mon_p1 && (preq4[1].ac_valid || preq4[1].cr_ready || preq4[1].cd_ready))
      p1_seen <= 1'b1;
    if (resp4.cr_valid && req4.cr_ready) cr_hs_cnt <= cr_hs_cnt + 1;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ports();
    for (int i = 0; i < 4; i++) presp4[i] = '0;
  endtask

  initial begin
    req4 = '0; req1 = '0; ini4 = '0; ini1 = '0;
    clr_ports();
    presp1[0] = '0;
    #2;
    chk1("rst_ac_ready", resp4.ac_ready, 1'b0);
    chk1("rst_cr_valid", resp4.cr_valid, 1'b0);
    chk1("rst_p0_ac_valid", preq4[0].ac_valid, 1'b0);
    chk1("rst_single_ac_ready", resp1.ac_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk1("idle_ac_ready", resp4.ac_ready, 1'b1);

    // broadcast with staggered acceptance, initiator 1
    mon_p1 = 1'b1;
    req4.ac_valid = 1'b1;
    req4.ac.addr = 32'h1000_0040; req4.ac.prot = 3'd2; req4.ac.snoop = 4'h7;
    ini4 = 2'd1;
    tick();
    req4 = '0; ini4 = 2'd3;
    presp4[0].ac_ready = 1'b1;
    #1;
    chk1("t1_p0_acv_c0", preq4[0].ac_valid, 1'b1);
    chk1("t1_p2_acv_c0", preq4[2].ac_valid, 1'b1);
    chk1("t1_p3_acv_c0", preq4[3].ac_valid, 1'b1);
    chkv("t1_p2_addr", 64'(preq4[2].ac.addr), 64'h1000_0040);
    chkv("t1_p3_snoop", 64'(preq4[3].ac.snoop), 64'h7);
    tick();
    presp4[0].ac_ready = 1'b0;
    #1;
    chk1("t1_p0_acv_c1", preq4[0].ac_valid, 1'b0);
    chk1("t1_p2_acv_c1", preq4[2].ac_valid, 1'b1);
    tick();
    presp4[2].ac_ready = 1'b1;
    tick();
    presp4[2].ac_ready = 1'b0;
    #1;
    chk1("t1_p2_acv_c3", preq4[2].ac_valid, 1'b0);
    chk1("t1_p3_acv_c3", preq4[3].ac_valid, 1'b1);
    tick();
    tick();
    presp4[3].ac_ready = 1'b1;
    #1;
    chk1("t1_p0_crr_bcast", preq4[0].cr_ready, 1'b0);
    tick();
    presp4[3].ac_ready = 1'b0;
    #1;
    chk1("t1_p0_crr", preq4[0].cr_ready, 1'b1);
    chk1("t1_p1_crr", preq4[1].cr_ready, 1'b0);
    chk1("t1_p2_crr", preq4[2].cr_ready, 1'b1);
    chk1("t1_p3_crr", preq4[3].cr_ready, 1'b1);
    chk1("t1_p3_acv_collect", preq4[3].ac_valid, 1'b0);
    presp4[0].cr_valid = 1'b1; presp4[2].cr_valid = 1'b1; presp4[3].cr_valid = 1'b1;
    tick();
    clr_ports();
    #1;
    chk1("t1_cr_valid", resp4.cr_valid, 1'b1);
    chkv("t1_cr_resp", 64'(resp4.cr_resp), 64'h0);
    hs0 = cr_hs_cnt;
    req4.cr_ready = 1'b1;
    tick();
    req4.cr_ready = 1'b0;
    #1;
    chk1("t1_back_idle", resp4.ac_ready, 1'b1);
    chk1("t1_cr_valid_low", resp4.cr_valid, 1'b0);
    chkv("t1_cr_once", 64'(cr_hs_cnt - hs0), 64'd1);
    mon_p1 = 1'b0;
    chk1("t1_p1_untouched", p1_seen, 1'b0);

    // response merge in scrambled order, then 10 cycles of upstream backpressure
    req4.ac_valid = 1'b1; req4.ac.addr = 32'h2000_0080; ini4 = 2'd0;
    for (int i = 0; i < 4; i++) presp4[i].ac_ready = 1'b1;
    tick();
    req4.ac_valid = 1'b0;
    #1;
    chk1("t2_p0_acv", preq4[0].ac_valid, 1'b0);
    chk1("t2_p1_acv", preq4[1].ac_valid, 1'b1);
    tick();
    presp4[3].cr_valid = 1'b1; presp4[3].cr_resp = 5'b00100;
    #1;
    chk1("t2_p3_crr", preq4[3].cr_ready, 1'b1);
    chk1("t2_p0_crr", preq4[0].cr_ready, 1'b0);
    tick();
    presp4[3].cr_valid = 1'b0; presp4[3].cr_resp = '0;
    presp4[1].cr_valid = 1'b1; presp4[1].cr_resp = 5'b01000;
    #1;
    chk1("t2_p3_crr_done", preq4[3].cr_ready, 1'b0);
    chk1("t2_no_early_cr", resp4.cr_valid, 1'b0);
    tick();
    presp4[1].cr_valid = 1'b0; presp4[1].cr_resp = '0;
    tick();
    presp4[2].cr_valid = 1'b1; presp4[2].cr_resp = 5'b10000;
    tick();
    presp4[2].cr_valid = 1'b0; presp4[2].cr_resp = '0;
    #1;
    hs0 = cr_hs_cnt;
    for (int c = 0; c < 10; c++) begin
      chk1("t2_bp_cr_valid", resp4.cr_valid, 1'b1);
      chkv("t2_bp_cr_resp", 64'(resp4.cr_resp), 64'h1c);
      chk1("t2_bp_no_cd_ready", preq4[1].cd_ready | preq4[2].cd_ready | preq4[3].cd_ready, 1'b0);
      tick();
      #1;
    end
    req4.cr_ready = 1'b1;
    tick();
    req4.cr_ready = 1'b0;
    #1;
    chk1("t2_back_idle", resp4.ac_ready, 1'b1);
    chkv("t2_cr_once", 64'(cr_hs_cnt - hs0), 64'd1);

    // data select (port 2) and drain (port 3), upstream cd_ready toggling
    req4.ac_valid = 1'b1; req4.ac.addr = 32'h3000_0000; ini4 = 2'd0;
    tick();
    req4.ac_valid = 1'b0;
    tick();
    presp4[1].cr_valid = 1'b1;
    presp4[2].cr_valid = 1'b1; presp4[2].cr_resp = 5'b00001;
    presp4[3].cr_valid = 1'b1; presp4[3].cr_resp = 5'b00001;
    tick();
    for (int i = 0; i < 4; i++) begin
      presp4[i].cr_valid = 1'b0; presp4[i].cr_resp = '0;
    end
    #1;
    chkv("t3_cr_resp", 64'(resp4.cr_resp), 64'h1);
    chk1("t3_no_cd_before_data", preq4[3].cd_ready, 1'b0);
    req4.cr_ready = 1'b1;
    tick();
    req4.cr_ready = 1'b0;
    p2 = 0; p3 = 0;
    for (int c = 0; c < 7; c++) begin
      up = (c % 2 == 0);
      req4.cd_ready = up;
      presp4[2].cd_valid = (p2 < 4); presp4[2].cd.data = 32'hA000_0000 + p2; presp4[2].cd.last = (p2 == 3);
      presp4[3].cd_valid = (p3 < 4); presp4[3].cd.data = 32'hB000_0000 + p3; presp4[3].cd.last = (p3 == 3);
      #1;
      chk1("t3_cd_valid", resp4.cd_valid, 1'b1);
      chkv("t3_cd_data", 64'(resp4.cd.data), 64'(32'hA000_0000 + p2));
      chk1("t3_cd_last", resp4.cd.last, (p2 == 3));
      chk1("t3_p2_cd_ready", preq4[2].cd_ready, up);
      chk1("t3_p3_cd_ready", preq4[3].cd_ready, (p3 < 4));
      chk1("t3_not_idle", resp4.ac_ready, 1'b0);
      if (up) p2++;
      if (p3 < 4) p3++;
      tick();
    end
    clr_ports();
    req4.cd_ready = 1'b0;
    #1;
    chk1("t3_back_idle", resp4.ac_ready, 1'b1);
    chk1("t3_p2_cd_ready_idle", preq4[2].cd_ready, 1'b0);

    // reset during the second data beat, then a fresh transaction
    for (int i = 0; i < 4; i++) presp4[i].ac_ready = 1'b1;
    req4.ac_valid = 1'b1; ini4 = 2'd0;
    tick();
    req4.ac_valid = 1'b0;
    tick();
    presp4[1].cr_valid = 1'b1; presp4[3].cr_valid = 1'b1;
    presp4[2].cr_valid = 1'b1; presp4[2].cr_resp = 5'b00001;
    tick();
    for (int i = 0; i < 4; i++) begin
      presp4[i].cr_valid = 1'b0; presp4[i].cr_resp = '0;
    end
    req4.cr_ready = 1'b1;
    tick();
    req4.cr_ready = 1'b0;
    req4.cd_ready = 1'b1;
    presp4[2].cd_valid = 1'b1; presp4[2].cd.data = 32'hC000_0000;
    tick();
    presp4[2].cd.data = 32'hC000_0001;
    #1;
    chk1("t4_beat2_fwd", resp4.cd_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("t4_rst_cd_valid", resp4.cd_valid, 1'b0);
    chk1("t4_rst_cd_ready", preq4[2].cd_ready, 1'b0);
    chk1("t4_rst_ac_ready", resp4.ac_ready, 1'b0);
    chk1("t4_rst_cr_valid", resp4.cr_valid, 1'b0);
    clr_ports();
    req4 = '0;
    tick();
    rst_n = 1'b1;
    #1;
    chk1("t4_post_rst_idle", resp4.ac_ready, 1'b1);
    for (int i = 0; i < 4; i++) presp4[i].ac_ready = 1'b1;
    req4.ac_valid = 1'b1; ini4 = 2'd3;
    tick();
    req4.ac_valid = 1'b0;
    #1;
    chk1("t4_p0_acv", preq4[0].ac_valid, 1'b1);
    chk1("t4_p3_acv", preq4[3].ac_valid, 1'b0);
    tick();
    #1;
    chk1("t4_collect_no_cr", resp4.cr_valid, 1'b0);
    for (int i = 0; i < 3; i++) presp4[i].cr_valid = 1'b1;
    presp4[3].cr_valid = 1'b1; presp4[3].cr_resp = 5'b00010;
    tick();
    clr_ports();
    #1;
    chk1("t4_cr_valid_lat3", resp4.cr_valid, 1'b1);
    chkv("t4_cr_resp", 64'(resp4.cr_resp), 64'h0);
    req4.cr_ready = 1'b1;
    tick();
    req4.cr_ready = 1'b0;
    #1;
    chk1("t4_back_idle", resp4.ac_ready, 1'b1);

    // single-port instance: nothing to broadcast
    req1.ac_valid = 1'b1; ini1 = 1'b0;
    #1;
    chk1("t5_ac_ready", resp1.ac_ready, 1'b1);
    tick();
    req1.ac_valid = 1'b0;
    #1;
    chk1("t5_cr_valid", resp1.cr_valid, 1'b1);
    chkv("t5_cr_resp", 64'(resp1.cr_resp), 64'h0);
    chk1("t5_p0_acv", preq1[0].ac_valid, 1'b0);
    req1.cr_ready = 1'b1;
    tick();
    req1.cr_ready = 1'b0;
    #1;
    chk1("t5_back_idle", resp1.ac_ready, 1'b1);
    chk1("t5_cr_valid_low", resp1.cr_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ccu_snoop_bcast.md
# ccu_snoop_bcast

Snoop fan-out/fan-in stage between the CCU control FSM and the per-master ACE snoop ports. It takes a single snoop request (AC) from the FSM and broadcasts it to every master except the initiator. It collects and merges the per-port snoop responses (CR) and forwards at most one snoop data stream (CD) back to the FSM, draining every other data stream. It handles one snoop transaction at a time.

## Interface
Parameters:
- NoMstPorts, 4, number of snooped ACE masters (>= 1)
- snoop_req_t, logic, ACE snoop request struct (ac_valid, ac{addr,prot,snoop}, cr_ready, cd_ready)
- snoop_resp_t, logic, ACE snoop response struct (ac_ready, cr_valid, cr_resp[4:0], cd_valid, cd{data,last})
- idx_t (derived), logic[max(1,$clog2(NoMstPorts))-1:0], master index type

Ports:
- clk_i, in, 1, clock
- rst_ni, in, 1, asynchronous active-low reset
- snoop_req_i, in, snoop_req_t, request from the CCU FSM
- initiator_i, in, idx_t, initiating master index; sampled with the AC handshake
- snoop_resp_o, out, snoop_resp_t, merged response to the CCU FSM
- snoop_req_o, out, snoop_req_t[NoMstPorts], per-master snoop request
- snoop_resp_i, in, snoop_resp_t[NoMstPorts], per-master snoop response

## Operation
- The design is one FSM with states IDLE, BCAST, COLLECT, RESP, DATA.
- **IDLE**
  - snoop_resp_o.ac_ready=1.
  - On snoop_req_i.ac_valid: latch ac into ac_q and set tgt_q = all-ones with bit initiator_i cleared.
  - If tgt_q would be 0 (NoMstPorts=1), go to RESP with crresp_q=0. Otherwise go to BCAST.
- **BCAST**
  - snoop_req_o[i].ac_valid = tgt_q[i] & ~acc_q[i], with ac=ac_q.
  - acc_q[i] sets on ac_valid&ac_ready. Ports accept independently, and valid stays asserted until accepted.
  - When (acc_q | newly accepted) == tgt_q, go to COLLECT.
- **COLLECT**
  - snoop_req_o[i].cr_ready = tgt_q[i] & ~got_q[i].
  - On each CR handshake: set got_q[i], OR cr_resp into crresp_q, and set dt_q[i] = cr_resp[0] (DataTransfer).
  - When all target ports have responded, go to RESP.
  - A CR handshake in the same cycle as the last AC acceptance is not possible, because cr_ready is 0 in BCAST.
- **RESP**
  - snoop_resp_o.cr_valid=1 and cr_resp=crresp_q.
  - On snoop_req_i.cr_ready: go to DATA if dt_q != 0, else IDLE.
- **DATA**
  - sel_q = lowest index set in dt_q, computed in the RESP cycle.
  - The selected port's cd_valid/cd is forwarded to snoop_resp_o, and its cd_ready comes from snoop_req_i.cd_ready.
  - Every other port in dt_q gets cd_ready=1 and its beats are discarded.
  - done_q[i] sets on a handshaken beat with last=1.
  - When done_q covers dt_q, go to IDLE and clear acc_q, got_q, dt_q, done_q and crresp_q.
- Ports outside tgt_q see all valid/ready signals at 0 for the whole transaction.
- cr_resp bit 1 (Error) from any port propagates through the OR merge; no special handling.

## Timing
- Reset: all outputs 0, state IDLE, all registers 0. Asserting reset mid-transaction drops all valids in the same cycle (asynchronous) with no completion.
- Outputs are combinational from state and registers. snoop_resp_o.cd* and the selected cd_ready pass through combinationally in DATA; there is no added data latency.
- Minimum latency, AC accept to merged cr_valid: 3 cycles (IDLE→BCAST→COLLECT→RESP), with all ports ready immediately.
- Valid is never deasserted before its handshake; data and control stay stable while valid is high.

## Structure
- ccu_pkg holds:
  - CR_DATA_TRANSFER=0, CR_ERROR=1, CR_PASS_DIRTY=2, CR_IS_SHARED=3, CR_WAS_UNIQUE=4
  - the state enum
- The lowest-index select uses the existing lzc common cell. No other sub-module.

## Test plan
- Broadcast and clean merge: NoMstPorts=4, initiator=1, ports 0/2/3 accept AC at cycles 0/2/5 and answer CR=0. Required: ac_valid is never seen on port 1, and a single cr_valid with cr_resp=0 follows, with no DATA state.
- Response merge: ports return cr_resp 5'b01000, 5'b10000 and 5'b00100 in any order. Required: merged cr_resp=5'b11100, presented exactly once.
- Data select and drain: ports 2 and 3 return DataTransfer=1, with 4-beat CD each.
  - Required: port 2's beats are forwarded in order with last on beat 4.
  - Required: port 3's beats are consumed while upstream cd_ready toggles.
  - Required: return to IDLE only after both last beats.
- Backpressure: upstream cr_ready is held low for 10 cycles. Required: cr_valid and cr_resp stay stable, and no CD ready is given early.
- Single port: NoMstPorts=1. Required: AC accepted, then cr_valid with cr_resp=0 on the next cycle, with no per-port activity.
- Reset mid-DATA: reset asserts during beat 2. Required: all outputs are 0 immediately, and after release a fresh AC completes normally.
